// File: rtl/result_readback_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : result_readback_if
// Description : Bundles the result-memory store port, the host read-request
//               channel and the read-response channel of result_readback.
//   wr_en/wr_addr/wr_data        store port from pipeline stage 4
//   req_valid/req_addr/req_ready read request channel (valid/ready)
//   rsp_valid/rsp_addr/rsp_data  read response channel, rsp_ready from host
//   inflight                     credits in use inside the block
//   Modport slave is the readback block; master is the pipeline/host side.
// Revision    : 1.0 - initial release
// ============================================================================
interface result_readback_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 3
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [ADDR_W-1:0] rsp_addr;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_ready;
    logic [CNT_W-1:0]  inflight;

    modport slave (
        input  wr_en, wr_addr, wr_data, req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_addr, rsp_data, inflight
    );

    modport master (
        output wr_en, wr_addr, wr_data, req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_addr, rsp_data, inflight
    );
endinterface
`default_nettype wire

// File: rtl/result_readback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : result_readback
// Description : Result RAM (2**ADDR_W x DATA_W) written by the pipeline store
//               port and read back by a host. Reads go through a 2-stage
//               pipeline (R1 address, R2 RAM read with write-first bypass)
//               into a response FIFO. Requests are only accepted while a FIFO
//               slot is reserved for them, so the FIFO never overflows.
//   clk  : clock, all state on posedge
//   rst  : asynchronous active-high reset (RAM contents are kept)
//   bus  : result_readback_if.slave - store port, request and response
//          channels, inflight credit count
// Revision    : 1.0 - initial release
// ============================================================================
module result_readback #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input wire logic         clk,
    input wire logic         rst,
    result_readback_if.slave bus
);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);

    // Storage without reset
    logic [DATA_W-1:0]  r_ram       [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0]  r_fifo_addr [0:FIFO_DEPTH-1];
    logic [DATA_W-1:0]  r_fifo_data [0:FIFO_DEPTH-1];

    // Read pipeline
    logic               r_r1_valid;
    logic [ADDR_W-1:0]  r_r1_addr;
    logic               r_r2_valid;
    logic [ADDR_W-1:0]  r_r2_addr;
    logic [DATA_W-1:0]  r_r2_data;

    // FIFO control and last-popped response (shown while the FIFO is empty)
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [ADDR_W-1:0]  r_last_addr;
    logic [DATA_W-1:0]  r_last_data;

    logic               w_push;
    logic               w_pop;
    logic               w_accept;
    logic               w_rsp_valid;
    logic               w_req_ready;
    logic [c_cnt_w-1:0] w_inflight;
    logic [c_cnt_w-1:0] w_count_next;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_data;

    assign w_head_addr = r_fifo_addr[r_rd_ptr];
    assign w_head_data = r_fifo_data[r_rd_ptr];
    assign w_rsp_valid = (r_count != '0);
    assign w_pop       = w_rsp_valid & bus.rsp_ready;
    assign w_push      = r_r2_valid;

    // Every request in R1/R2 already owns a FIFO slot; a pop this edge frees
    // one, which is why a full block can still accept when the head leaves.
    assign w_inflight  = {{(c_cnt_w-1){1'b0}}, r_r1_valid}
                       + {{(c_cnt_w-1){1'b0}}, r_r2_valid}
                       + r_count;
    assign w_req_ready = (w_inflight < c_depth) | w_pop;
    assign w_accept    = bus.req_valid & w_req_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Store port
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            r_ram[bus.wr_addr] <= bus.wr_data;
        end
    end

    // R2 data path; a store to the same address on this edge wins over the
    // RAM's old contents (write-first).
    always_ff @(posedge clk) begin
        r_r2_addr <= r_r1_addr;
        if (bus.wr_en && (bus.wr_addr == r_r1_addr)) begin
            r_r2_data <= bus.wr_data;
        end else begin
            r_r2_data <= r_ram[r_r1_addr];
        end
    end

    // FIFO payload
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= r_r2_addr;
            r_fifo_data[r_wr_ptr] <= r_r2_data;
        end
    end

    // Control state; requests caught in R1/R2 at reset are simply dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_r1_valid  <= 1'b0;
            r_r1_addr   <= '0;
            r_r2_valid  <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_last_addr <= '0;
            r_last_data <= '0;
        end else begin
            r_r1_valid <= w_accept;
            if (w_accept) begin
                r_r1_addr <= bus.req_addr;
            end
            r_r2_valid <= r_r1_valid;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_last_addr <= w_head_addr;
                r_last_data <= w_head_data;
            end
            r_count <= w_count_next;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_addr  = w_rsp_valid ? w_head_addr : r_last_addr;
    assign bus.rsp_data  = w_rsp_valid ? w_head_data : r_last_data;
    assign bus.inflight  = w_inflight;
endmodule
`default_nettype wire

// File: tb/tb_result_readback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_result_readback
// Description : Directed and random self-checking bench for result_readback.
//               Inputs change 1ns after a rising edge; outputs are sampled
//               just after that, well away from the next edge. A request
//               accepted at edge N is presented from edge N+2 onwards, so a
//               ready consumer takes it at edge N+3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_readback;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 4;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [15:0] mdl_ram [0:255];
    rsp_t        mdl_q[$];
    logic        m_r1_v, m_r2_v;
    logic [7:0]  m_r1_a, m_r2_a;
    logic [15:0] m_r2_d;

    result_readback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(3)) bus ();

    result_readback #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [15:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
        mdl_ram[a]  = d;
    endtask

    task automatic fill_ram();
        for (int i = 0; i < 256; i++) begin
            write_word(8'(i), {8'(i), 8'(i) ^ 8'hC3});
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step(); step();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_addr !== 8'h00 || bus.rsp_data !== 16'h0000 ||
            bus.inflight !== 3'd0) begin
            errors++;
            $display("FAIL reset_values: valid=%b addr=%0h data=%0h inflight=%0d expected 0/0/0/0",
                     bus.rsp_valid, bus.rsp_addr, bus.rsp_data, bus.inflight);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready);
        end
        // three requests with the consumer stalled: one each in R1, R2, FIFO
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req_addr = 8'(i);
            step();
        end
        bus.req_valid = 1'b0;
        checks++;
        if (bus.inflight !== 3'd3 || bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_preburst: inflight=%0d valid=%b expected 3/1",
                     bus.inflight, bus.rsp_valid);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.inflight !== 3'd0) begin
            errors++;
            $display("FAIL reset_async: valid=%b inflight=%0d expected 0/0",
                     bus.rsp_valid, bus.inflight);
        end
        step(); step();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.inflight !== 3'd0) begin
                errors++;
                $display("FAIL reset_stale: cycle %0d valid=%b inflight=%0d expected 0/0",
                         i, bus.rsp_valid, bus.inflight);
            end
            step();
        end
        idle();
    endtask

    task automatic test_basic();
        write_word(8'h10, 16'hBEEF);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 8'h10;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: got %b expected 1", bus.req_ready);
        end
        step();                              // edge N
        bus.req_valid = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_n: valid=%b expected 0", bus.rsp_valid);
        end
        step();                              // edge N+1
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_n1: valid=%b expected 0", bus.rsp_valid);
        end
        step();                              // edge N+2, taken at N+3
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_addr !== 8'h10 || bus.rsp_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL basic_rsp: valid=%b addr=%0h data=%0h expected 1/10/beef",
                     bus.rsp_valid, bus.rsp_addr, bus.rsp_data);
        end
        step();                              // edge N+3 pops it
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.inflight !== 3'd0 ||
            bus.rsp_addr !== 8'h10 || bus.rsp_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL basic_hold: valid=%b inflight=%0d addr=%0h data=%0h expected 0/0/10/beef",
                     bus.rsp_valid, bus.inflight, bus.rsp_addr, bus.rsp_data);
        end
        idle();
    endtask

    // Read 'ra' while storing 'wa'=wd on the R2 capture edge.
    task automatic bypass_case(input logic [7:0] ra, input logic [7:0] wa,
                               input logic [15:0] wd, input logic [15:0] exp_d,
                               input string name);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = ra;
        step();                              // edge N
        bus.req_valid = 1'b0;
        bus.wr_en     = 1'b1;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
        step();                              // edge N+1
        bus.wr_en     = 1'b0;
        mdl_ram[wa]   = wd;
        step();                              // edge N+2
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_addr !== ra || bus.rsp_data !== exp_d) begin
            errors++;
            $display("FAIL %s: valid=%b addr=%0h data=%0h expected 1/%0h/%0h",
                     name, bus.rsp_valid, bus.rsp_addr, bus.rsp_data, ra, exp_d);
        end
        step();
        idle();
    endtask

    task automatic test_bypass();
        write_word(8'h20, 16'h1111);
        write_word(8'h21, 16'h3333);
        bypass_case(8'h20, 8'h20, 16'h2222, 16'h2222, "bypass_same");
        bypass_case(8'h21, 8'h22, 16'h4444, 16'h3333, "bypass_other");
    endtask

    task automatic test_backpressure();
        int   accepted = 0;
        int   got      = 0;
        int   next_req = 4;
        logic acc_pat [0:5];
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.req_addr = 8'(i);
            #1;
            acc_pat[i] = bus.req_ready;
            if (bus.req_ready === 1'b1) accepted++;
            step();
        end
        checks++;
        if (accepted != 4 || acc_pat[3] !== 1'b1 || acc_pat[4] !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept_count: accepted=%0d expected 4", accepted);
        end
        checks++;
        if (bus.req_ready !== 1'b0 || bus.inflight !== 3'd4 || bus.rsp_valid !== 1'b1 ||
            bus.rsp_addr !== 8'h00) begin
            errors++;
            $display("FAIL bp_full: ready=%b inflight=%0d valid=%b addr=%0h expected 0/4/1/0",
                     bus.req_ready, bus.inflight, bus.rsp_valid, bus.rsp_addr);
        end
        step();
        checks++;
        if (bus.rsp_addr !== 8'h00 || bus.rsp_data !== mdl_ram[0] || bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_stable: addr=%0h data=%0h expected 0/%0h",
                     bus.rsp_addr, bus.rsp_data, mdl_ram[0]);
        end
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 30 && got < 7; c++) begin
            bus.req_valid = (next_req <= 5);
            bus.req_addr  = 8'(next_req);
            #1;
            if (bus.rsp_valid === 1'b1) begin
                checks++;
                if (got > 5 || bus.rsp_addr !== 8'(got) || bus.rsp_data !== mdl_ram[8'(got)]) begin
                    errors++;
                    $display("FAIL bp_order: index %0d addr=%0h data=%0h", got,
                             bus.rsp_addr, bus.rsp_data);
                end
                got++;
            end
            if (bus.req_valid && bus.req_ready === 1'b1) next_req++;
            step();
        end
        checks++;
        if (got != 6 || bus.inflight !== 3'd0) begin
            errors++;
            $display("FAIL bp_total: responses=%0d inflight=%0d expected 6/0", got, bus.inflight);
        end
        idle();
    endtask

    task automatic test_streaming();
        int issued = 0;
        int rcv    = 0;
        int stalls = 0;
        int first  = -1;
        int last   = -1;
        int bad    = 0;
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 300 && rcv < 256; c++) begin
            bus.req_valid = (issued < 256);
            bus.req_addr  = 8'(issued);
            #1;
            if (bus.req_valid && bus.req_ready !== 1'b1) stalls++;
            if (bus.rsp_valid === 1'b1) begin
                if (first < 0) first = c;
                last = c;
                if (bus.rsp_addr !== 8'(rcv) || bus.rsp_data !== mdl_ram[8'(rcv)]) bad++;
                rcv++;
            end
            if (bus.req_valid && bus.req_ready === 1'b1) issued++;
            step();
        end
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL stream_stalls: got %0d expected 0", stalls);
        end
        checks++;
        if (rcv != 256 || bad != 0) begin
            errors++;
            $display("FAIL stream_data: responses=%0d bad=%0d expected 256/0", rcv, bad);
        end
        checks++;
        if (first != 3 || last != 258) begin
            errors++;
            $display("FAIL stream_timing: first=%0d last=%0d expected 3/258", first, last);
        end
        idle();
    endtask

    task automatic rand_cycle(input logic drain);
        int   exp_infl;
        logic exp_ready;
        logic acc;
        rsp_t h;
        bus.wr_en     = drain ? 1'b0 : ($urandom_range(0, 3) == 0);
        bus.wr_addr   = 8'($urandom_range(0, 15));
        bus.wr_data   = 16'($urandom);
        bus.req_valid = drain ? 1'b0 : 1'($urandom_range(0, 1));
        bus.req_addr  = 8'($urandom_range(0, 15));
        bus.rsp_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
        #1;
        exp_infl  = int'(m_r1_v) + int'(m_r2_v) + mdl_q.size();
        exp_ready = (exp_infl < FIFO_DEPTH) || (mdl_q.size() != 0 && bus.rsp_ready);
        checks++;
        if (bus.inflight !== 3'(exp_infl) || bus.inflight > 3'(FIFO_DEPTH) ||
            bus.req_ready !== exp_ready || bus.rsp_valid !== (mdl_q.size() != 0)) begin
            errors++;
            $display("FAIL rand_ctrl: inflight=%0d ready=%b valid=%b expected %0d/%b/%b",
                     bus.inflight, bus.req_ready, bus.rsp_valid, exp_infl, exp_ready,
                     mdl_q.size() != 0);
        end
        if (mdl_q.size() != 0) begin
            h = mdl_q[0];
            checks++;
            if (bus.rsp_addr !== h.a || bus.rsp_data !== h.d) begin
                errors++;
                $display("FAIL rand_data: addr=%0h data=%0h expected %0h/%0h",
                         bus.rsp_addr, bus.rsp_data, h.a, h.d);
            end
            if (bus.rsp_ready) void'(mdl_q.pop_front());
        end
        acc = bus.req_valid && exp_ready;
        @(posedge clk);
        if (bus.wr_en) mdl_ram[bus.wr_addr] = bus.wr_data;
        if (m_r2_v) mdl_q.push_back('{a: m_r2_a, d: m_r2_d});
        m_r2_v = m_r1_v;
        m_r2_a = m_r1_a;
        m_r2_d = mdl_ram[m_r1_a];
        m_r1_v = acc;
        m_r1_a = bus.req_addr;
        #1;
    endtask

    task automatic test_random();
        m_r1_v = 1'b0;
        m_r2_v = 1'b0;
        m_r1_a = '0;
        m_r2_a = '0;
        m_r2_d = '0;
        mdl_q.delete();
        for (int i = 0; i < 10000; i++) rand_cycle(1'b0);
        for (int i = 0; i < 12; i++) rand_cycle(1'b1);
        checks++;
        if (mdl_q.size() != 0 || bus.inflight !== 3'd0) begin
            errors++;
            $display("FAIL rand_drain: model=%0d inflight=%0d expected 0/0",
                     mdl_q.size(), bus.inflight);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        fill_ram();
        test_basic();
        test_bypass();
        test_backpressure();
        test_streaming();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
